movx_ctrl_fsm: RTL

Parametrised control FSM for the MOV instruction family: MOVI (zero-extended immediate), MOVIS (sign-extended immediate) and MOV (register to register).
It sequences PC increment, bus source enable and one-hot destination register load, then reports completion.
It sits beside the other per-opcode controllers, fed from the instruction register and driving the shared bus/register-enable fabric.
It generalises the fixed 5-register MOVI controller to N registers, any data width and two extra modes, and adds a start/done handshake plus illegal-operand detection.

---
 rtl/movx_ctrl_if.sv | 28 ++
 rtl/movx_ctrl_fsm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/movx_ctrl_if.sv
// Handshake and bus/register-enable bundle between the instruction front end
// and the MOV-family controller.
interface movx_ctrl_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 5
);
    logic                start;
    logic [15:0]         instr;
    logic                pc_inc;
    logic                imm_out_en;
    logic [DATA_W-1:0]   imm_value;
    logic [NUM_REGS-1:0] reg_out;
    logic [NUM_REGS-1:0] reg_in;
    logic                busy;
    logic                done;
    logic                err;

    // The front end issues instructions; the controller answers with strobes.
    modport master (
        output start, instr,
        input  pc_inc, imm_out_en, imm_value, reg_out, reg_in, busy, done, err
    );

    modport slave (
        input  start, instr,
        output pc_inc, imm_out_en, imm_value, reg_out, reg_in, busy, done, err
    );
endinterface

// File: rtl/movx_ctrl_fsm.sv
// Control FSM for MOV / MOVI / MOVIS: sequences PC increment, bus source enable
// and one-hot destination load for N registers, with start/done handshake.
module movx_ctrl_fsm #(
    parameter int         DATA_W    = 16,
    parameter int         NUM_REGS  = 5,
    parameter logic [3:0] OPC_MOV   = 4'h6,
    parameter logic [3:0] OPC_MOVI  = 4'h7,
    parameter logic [3:0] OPC_MOVIS = 4'h8
) (
    input  logic       clk,
    input  logic       rst,
    movx_ctrl_if.slave ctrl
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INC   = 3'd1,
        S_DRIVE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

    state_t              r_state;
    state_t              w_nextState;
    logic [15:0]         r_instr;

    logic [3:0]          w_reqOpc;
    logic                w_accept;
    logic [3:0]          w_opc;
    logic [5:0]          w_dst;
    logic [5:0]          w_src;
    logic [5:0]          w_imm6;
    logic                w_isMov;
    logic                w_isMovis;
    logic                w_illegal;
    logic [NUM_REGS-1:0] w_dstOneHot;
    logic [NUM_REGS-1:0] w_srcOneHot;
    logic [DATA_W-1:0]   w_immZext;
    logic [DATA_W-1:0]   w_immSext;

    logic                w_pcInc;
    logic                w_immOutEn;
    logic [DATA_W-1:0]   w_immValue;
    logic [NUM_REGS-1:0] w_regOut;
    logic [NUM_REGS-1:0] w_regIn;
    logic                w_busy;
    logic                w_done;
    logic                w_err;

    assign w_reqOpc = ctrl.instr[15:12];
    assign w_accept = ctrl.start &&
                      ((w_reqOpc == OPC_MOV) || (w_reqOpc == OPC_MOVI) || (w_reqOpc == OPC_MOVIS));

    // Everything past IDLE works only from the latched copy of the instruction.
    assign w_opc     = r_instr[15:12];
    assign w_dst     = r_instr[11:6];
    assign w_src     = r_instr[5:0];
    assign w_imm6    = r_instr[5:0];
    assign w_isMov   = (w_opc == OPC_MOV);
    assign w_isMovis = (w_opc == OPC_MOVIS);
    assign w_illegal = ({1'b0, w_dst} >= NUM_REGS_W) ||
                       (w_isMov && ({1'b0, w_src} >= NUM_REGS_W));

    always_comb begin
        w_dstOneHot = '0;
        w_srcOneHot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_dstOneHot[i] = (w_dst == 6'(i));
            w_srcOneHot[i] = (w_src == 6'(i));
        end
    end

    // A 6-bit data path has no upper bits to extend into.
    generate
        if (DATA_W > 6) begin : g_ext
            assign w_immZext = {{(DATA_W-6){1'b0}}, w_imm6};
            assign w_immSext = {{(DATA_W-6){w_imm6[5]}}, w_imm6};
        end else begin : g_noext
            assign w_immZext = w_imm6;
            assign w_immSext = w_imm6;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= '0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_instr <= ctrl.instr;
        end
    end

    always_comb begin
        w_nextState = S_IDLE;
        case (r_state)
            S_IDLE:  w_nextState = w_accept ? S_INC : S_IDLE;
            S_INC:   w_nextState = w_illegal ? S_ERR : S_DRIVE;
            S_DRIVE: w_nextState = S_WRITE;
            S_WRITE: w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            S_ERR:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Source enable is held through WRITE so the bus is stable while the load fires.
    always_comb begin
        w_pcInc    = 1'b0;
        w_immOutEn = 1'b0;
        w_immValue = '0;
        w_regOut   = '0;
        w_regIn    = '0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_INC: begin
                w_pcInc = 1'b1;
            end
            S_DRIVE, S_WRITE: begin
                if (w_isMov) begin
                    w_regOut = w_srcOneHot;
                end else begin
                    w_immOutEn = 1'b1;
                    w_immValue = w_isMovis ? w_immSext : w_immZext;
                end
                if (r_state == S_WRITE) begin
                    w_regIn = w_dstOneHot;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            S_ERR: begin
                w_done = 1'b1;
                w_err  = 1'b1;
            end
            default: begin
                w_pcInc = 1'b0;
            end
        endcase
    end

    assign w_busy = (r_state != S_IDLE);

    assign ctrl.pc_inc     = w_pcInc;
    assign ctrl.imm_out_en = w_immOutEn;
    assign ctrl.imm_value  = w_immValue;
    assign ctrl.reg_out    = w_regOut;
    assign ctrl.reg_in     = w_regIn;
    assign ctrl.busy       = w_busy;
    assign ctrl.done       = w_done;
    assign ctrl.err        = w_err;

endmodule
